// File: rtl/qdr_vacc_arb_if.sv
// Bus bundle for qdr_vacc_arb: port A commands, port B request/ack,
// returned read data for both ports, and the registered QDR command side.
interface qdr_vacc_arb_if #(
  parameter int ADDR_BITS = 12,
  parameter int DATA_BITS = 36
);
  // Port A (vacc controller, never stalled)
  logic                 a_we;
  logic                 a_re;
  logic [ADDR_BITS-1:0] a_addr;
  logic [DATA_BITS-1:0] a_wdata;
  logic [DATA_BITS-1:0] a_rdata;
  logic                 a_rvld;
  // Port B (register access, request/acknowledge)
  logic                 b_req;
  logic                 b_we;
  logic [ADDR_BITS-1:0] b_addr;
  logic [DATA_BITS-1:0] b_wdata;
  logic                 b_ack;
  logic [DATA_BITS-1:0] b_rdata;
  logic                 b_rvld;
  // Status
  logic                 b_starved;
  logic                 a_clash;
  // QDR side
  logic                 qdr_we;
  logic                 qdr_re;
  logic [ADDR_BITS-1:0] qdr_addr;
  logic [DATA_BITS-1:0] qdr_wdata;
  logic [DATA_BITS-1:0] qdr_rdata;

  // Arbiter view
  modport slave (
    input  a_we, a_re, a_addr, a_wdata,
    output a_rdata, a_rvld,
    input  b_req, b_we, b_addr, b_wdata,
    output b_ack, b_rdata, b_rvld,
    output b_starved, a_clash,
    output qdr_we, qdr_re, qdr_addr, qdr_wdata,
    input  qdr_rdata
  );

  // Driver view (controller, register port and QDR together)
  modport master (
    output a_we, a_re, a_addr, a_wdata,
    input  a_rdata, a_rvld,
    output b_req, b_we, b_addr, b_wdata,
    input  b_ack, b_rdata, b_rvld,
    input  b_starved, a_clash,
    input  qdr_we, qdr_re, qdr_addr, qdr_wdata,
    output qdr_rdata
  );
endinterface

// File: rtl/qdr_vacc_arb.sv
// Two-port QDR command arbiter. Port A has absolute priority; port B is
// acked on any cycle A is idle. All QDR commands are registered, and read
// data is steered back to its issuing port by an ownership pipeline whose
// depth matches the QDR read latency.
module qdr_vacc_arb #(
  parameter int ADDR_BITS    = 12,
  parameter int DATA_BITS    = 36,
  parameter int QDR_LATENCY  = 10,
  parameter int STARVE_LIMIT = 1024,
  parameter int STARVE_BITS  = 11
) (
  input  logic           clk,
  input  logic           rst_n,
  qdr_vacc_arb_if.slave  bus
);

  localparam int PIPE_DEPTH = QDR_LATENCY + 1;
  localparam logic [STARVE_BITS-1:0] STARVE_MAX = STARVE_BITS'(STARVE_LIMIT);

  logic a_cmd, a_rd, b_ack, b_rd;

  logic                   qdr_we_q, qdr_we_d;
  logic                   qdr_re_q, qdr_re_d;
  logic [ADDR_BITS-1:0]   qdr_addr_q, qdr_addr_d;
  logic [DATA_BITS-1:0]   qdr_wdata_q, qdr_wdata_d;
  // Each entry is {read issued by A, read issued by B}
  logic [1:0]             pipe_q [PIPE_DEPTH];
  logic [1:0]             pipe_d [PIPE_DEPTH];
  logic                   a_rvld_q, a_rvld_d;
  logic                   b_rvld_q, b_rvld_d;
  logic [DATA_BITS-1:0]   a_rdata_q, a_rdata_d;
  logic [DATA_BITS-1:0]   b_rdata_q, b_rdata_d;
  logic [STARVE_BITS-1:0] starve_cnt_q, starve_cnt_d;
  logic                   b_starved_q, b_starved_d;
  logic                   a_clash_q, a_clash_d;

  // Arbitration: A wins; a simultaneous A write+read keeps only the write
  always_comb begin
    a_cmd = bus.a_we | bus.a_re;
    a_rd  = bus.a_re & ~bus.a_we;
    b_ack = rst_n & bus.b_req & ~a_cmd;
    b_rd  = b_ack & ~bus.b_we;
  end

  // Next command register contents; address/data hold when nothing issues
  always_comb begin
    qdr_we_d    = bus.a_we | (b_ack & bus.b_we);
    qdr_re_d    = a_rd | b_rd;
    qdr_addr_d  = qdr_addr_q;
    qdr_wdata_d = qdr_wdata_q;
    if (a_cmd) begin
      qdr_addr_d  = bus.a_addr;
      qdr_wdata_d = bus.a_wdata;
    end else if (b_ack) begin
      qdr_addr_d  = bus.b_addr;
      qdr_wdata_d = bus.b_wdata;
    end
  end

  // Ownership shift and read-data steering from the pipeline tail
  always_comb begin
    pipe_d[0] = {a_rd, b_rd};
    for (int i = 1; i < PIPE_DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    a_rvld_d  = pipe_q[PIPE_DEPTH-1][1];
    b_rvld_d  = pipe_q[PIPE_DEPTH-1][0];
    a_rdata_d = a_rvld_d ? bus.qdr_rdata : a_rdata_q;
    b_rdata_d = b_rvld_d ? bus.qdr_rdata : b_rdata_q;
  end

  // Starvation counter (saturating) and the two sticky status flags
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.b_req || b_ack) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != STARVE_MAX) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
    b_starved_d = b_starved_q | (starve_cnt_d == STARVE_MAX);
    a_clash_d   = a_clash_q | (bus.a_we & bus.a_re);
  end

  // State register; reset also flushes in-flight read ownership
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      qdr_we_q     <= 1'b0;
      qdr_re_q     <= 1'b0;
      qdr_addr_q   <= '0;
      qdr_wdata_q  <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
      a_rvld_q     <= 1'b0;
      b_rvld_q     <= 1'b0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
      starve_cnt_q <= '0;
      b_starved_q  <= 1'b0;
      a_clash_q    <= 1'b0;
    end else begin
      qdr_we_q     <= qdr_we_d;
      qdr_re_q     <= qdr_re_d;
      qdr_addr_q   <= qdr_addr_d;
      qdr_wdata_q  <= qdr_wdata_d;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
      a_rvld_q     <= a_rvld_d;
      b_rvld_q     <= b_rvld_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
      starve_cnt_q <= starve_cnt_d;
      b_starved_q  <= b_starved_d;
      a_clash_q    <= a_clash_d;
    end
  end

  assign bus.b_ack     = b_ack;
  assign bus.qdr_we    = qdr_we_q;
  assign bus.qdr_re    = qdr_re_q;
  assign bus.qdr_addr  = qdr_addr_q;
  assign bus.qdr_wdata = qdr_wdata_q;
  assign bus.a_rvld    = a_rvld_q;
  assign bus.b_rvld    = b_rvld_q;
  assign bus.a_rdata   = a_rdata_q;
  assign bus.b_rdata   = b_rdata_q;
  assign bus.b_starved = b_starved_q;
  assign bus.a_clash   = a_clash_q;

endmodule

// File: doc/qdr_vacc_arb.md
# qdr_vacc_arb

Two-port command arbiter that shares one QDR SRAM between the vector-accumulator controller (port A, fixed-rate, never stalled) and a software/register access port (port B, request/acknowledge). It sits between the vacc controller's QDR command outputs and the QDR interface. Every command going to the QDR is registered here. Returning read data is routed to the port that issued the read, using a latency-matched ownership pipeline. A sticky starvation flag reports when port B has been locked out too long.

## Interface
- ADDR_BITS, 12, QDR word-pair address width
- DATA_BITS, 36, QDR data width
- QDR_LATENCY, 10, clocks from registered qdr_re to valid qdr_rdata (≥1)
- STARVE_LIMIT, 1024, consecutive un-acked b_req cycles that set b_starved (≥1)
- STARVE_BITS, 11, counter width; must hold STARVE_LIMIT

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  synchronous, active-low reset
- a_we, a_re  in  1 each  port A write/read command
- a_addr  in  ADDR_BITS  port A address
- a_wdata  in  DATA_BITS  port A write data
- a_rdata  out  DATA_BITS  read data for port A
- a_rvld  out  1  a_rdata valid
- b_req  in  1  port B request; held until b_ack
- b_we  in  1  B command type: 1 = write, 0 = read; held with b_req
- b_addr  in  ADDR_BITS  B address, held with b_req
- b_wdata  in  DATA_BITS  B write data, held with b_req
- b_ack  out  1  B command accepted this cycle
- b_rdata  out  DATA_BITS  read data for port B
- b_rvld  out  1  b_rdata valid
- b_starved  out  1  sticky starvation flag
- a_clash  out  1  sticky error: a_we and a_re high in the same cycle
- qdr_we, qdr_re  out  1 each  registered QDR command
- qdr_addr  out  ADDR_BITS  registered QDR address
- qdr_wdata  out  DATA_BITS  registered QDR write data
- qdr_rdata  in  DATA_BITS  QDR read data

## Operation
- **Priority:** port A always wins. A command from port A in cycle T is issued, and port B is not acked in T.
- **B acknowledge:** b_ack = rst_n & b_req & ~a_we & ~a_re. This is combinational from inputs sampled in cycle T. B's command is issued in the same cycle T. B must hold its request fields until it sees b_ack. B may drop b_req without being acked; nothing is issued in that case.
- **Command register,** every cycle:
  - qdr_we ← (a_we) | (b_ack & b_we)
  - qdr_re ← (a_re & ~a_we) | (b_ack & ~b_we)
  - qdr_addr and qdr_wdata take the source selected for that cycle: A if a_we|a_re, else B if b_ack, else hold the previous value.
- **a_clash:** if a_we & a_re, the write takes precedence, the read is dropped, and a_clash is set.
- **Ownership pipeline:** a shift register of QDR_LATENCY+1 entries carries {rd_A, rd_B}.
  - It is loaded at the cycle the command register loads, with rd_A = A read issued and rd_B = B read issued.
  - Output stage, registered: when the pipeline tail has rd_A, a_rdata ← qdr_rdata and a_rvld ← 1; otherwise a_rvld ← 0. The B port behaves the same way with rd_B.
  - a_rdata and b_rdata hold their last value when not valid.
- **Starvation counter:**
  - Increments each cycle that b_req is high and b_ack is low, saturating at STARVE_LIMIT.
  - Clears to 0 on b_ack or when b_req is low.
  - b_starved is set when the counter reaches STARVE_LIMIT.
  - b_starved and a_clash clear only on reset.
- **Reset (rst_n = 0 at an edge):**
  - qdr_we, qdr_re, a_rvld, b_rvld, b_starved and a_clash go to 0.
  - qdr_addr, qdr_wdata, a_rdata and b_rdata go to 0.
  - The ownership pipeline and the starvation counter clear.
  - b_ack is 0 while rst_n is low.
  - A reset in the middle of an operation drops in-flight reads: no rvld for them after reset deasserts, even if the QDR still returns data.

## Timing
- A command sampled at edge T appears on qdr_* during cycle T+1.
- Read data: qdr_rdata is valid at T+1+QDR_LATENCY. a_rvld/b_rvld and the rdata outputs are high/valid at T+2+QDR_LATENCY. Total read latency from command to rvld is QDR_LATENCY+2.
- Throughput: one command per cycle. Back-to-back reads from mixed ports return in issue order, each tagged correctly.
- With A's alternating-enable traffic (command every other cycle), B gets a slot on every idle cycle. B's worst-case wait is bounded only by A activity, which is why the starvation flag exists.
- b_rvld and a_rvld are never high in the same cycle.

## Test plan
- **Reset:**
  - Stimulus: rst_n = 0 for 3 cycles while a_we = 1 and b_req = 1.
  - Required response: all outputs 0 and b_ack = 0. The first command appears on qdr_* at the edge after rst_n = 1, plus 1.
- **B read alone:**
  - Stimulus: A idle, b_req = 1, b_we = 0, b_addr = 0x005, with a QDR model returning 0x123456789.
  - Required response: b_ack in the same cycle; qdr_re = 1 and qdr_addr = 0x005 the next cycle; b_rvld = 1 with b_rdata = 0x123456789 exactly QDR_LATENCY+2 cycles after b_ack. a_rvld stays 0.
- **Interleave:**
  - Stimulus: a_re toggling every cycle (addresses 0, 1, 2, …) while b_req is held for a read of 0xFFF.
  - Required response: b_ack only on cycles where A is idle. The returned data stream has exactly one b_rvld, for 0xFFF, and the a_rvld data is in order 0, 1, 2.
- **Starvation:**
  - Stimulus: STARVE_LIMIT = 8; a_we held high continuously with b_req = 1.
  - Required response: b_starved rises after the 8th un-acked cycle and stays high after A goes idle and B is acked.
- **Clash:**
  - Stimulus: a_we = 1 and a_re = 1 in one cycle, addr 0x010.
  - Required response: qdr_we = 1 and qdr_re = 0 the next cycle; a_clash is sticky 1; no a_rvld is produced.
- **Reset mid-flight:**
  - Stimulus: issue a B read, then pulse rst_n low for 1 cycle 3 cycles later.
  - Required response: no b_rvld occurs for that read.
